// File: rtl/fft_axi_sample_writer.sv
// Streams a frame of 16-bit samples into the FFT sample memory as AXI INCR write bursts,
// with one burst outstanding at a time. FFT_WR_ZERO_PAD_EN: an early s_last zero-pads the whole frame.
module fft_axi_sample_writer #(
  parameter logic [11:0] BASE_ADDR = 12'h000,
  parameter int          MAX_BURST = 16,
  parameter logic [1:0]  WR_ID     = 2'b00
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_last,
  input  logic [11:0] frame_len,
  output logic [11:0] AWADDR,
  output logic [7:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic [1:0]  AWID,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [15:0] WDATA,
  output logic [1:0]  WSTRB,
  output logic        WVALID,
  output logic        WLAST,
  input  logic        WREADY,
  input  logic        BVALID,
  input  logic [1:0]  BID,
  output logic        BREADY,
  output logic        busy,
  output logic        frame_done,
  output logic        cfg_err,
  output logic        len_err,
  output logic        bid_err
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

  localparam logic [8:0] MAXB = 9'(MAX_BURST);

  state_t      state_q, state_d;
  logic [11:0] len_q, len_d, sent_q, sent_d;
  logic [8:0]  loaded_q, loaded_d;
  logic [15:0] wdata_q, wdata_d;
  logic        pad_q, pad_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
  logic        len_err_q, len_err_d, bid_err_q, bid_err_d;

  logic        frame_ok, w_slot, room, take, s_fire, pad_fire, early, missing, last_w, stop_early;
  logic [11:0] remaining, idx, burst_end;
  logic [8:0]  burst_len, awlen_full;

  assign frame_ok  = (frame_len != 12'd0) && (frame_len <= 12'd2048);
  assign remaining = len_q - sent_q;
  assign burst_len = (remaining > {3'b000, MAXB}) ? MAXB : remaining[8:0];
  assign burst_end = sent_q + {3'b000, burst_len};
  assign w_slot    = !wvalid_q || WREADY;
  assign room      = loaded_q < burst_len;
  assign take      = (state_q == S_DATA) && w_slot && room;
  assign s_fire    = s_valid && s_ready;
  assign pad_fire  = take && pad_q;
  assign idx       = sent_q + {3'b000, loaded_q};
  assign early     = s_last && ((idx + 12'd1) < len_q);
  assign missing   = !s_last && ((idx + 12'd1) == len_q);
  assign last_w    = wvalid_q && WREADY && wlast_q;

`ifdef FFT_WR_ZERO_PAD_EN
  assign stop_early = 1'b0;   // padding keeps issuing bursts until frame_len beats are written
`else
  assign stop_early = pad_q;
`endif

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (s_valid && frame_ok) state_d = S_ADDR;
      S_ADDR:  if (AWREADY) state_d = S_DATA;
      S_DATA:  if (last_w) state_d = S_RESP;
      S_RESP:  if (BVALID) state_d = (burst_end >= len_q || stop_early) ? S_DONE : S_ADDR;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    awlen_full = burst_len - 9'd1;
    AWVALID    = (state_q == S_ADDR);
    AWADDR     = AWVALID ? BASE_ADDR + (sent_q << 1) : 12'h000;
    AWLEN      = AWVALID ? awlen_full[7:0] : 8'h00;
    s_ready    = take && !pad_q;
    BREADY     = (state_q == S_RESP);
    busy       = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_RESP);
    frame_done = (state_q == S_DONE);
    cfg_err    = (state_q == S_IDLE) && !frame_ok;
  end

  always_comb begin
    len_d     = len_q;
    sent_d    = sent_q;
    loaded_d  = loaded_q;
    pad_d     = pad_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    wdata_d   = wdata_q;
    bid_err_d = bid_err_q;
    len_err_d = s_fire && (early || missing);
    if (state_q == S_IDLE && s_valid && frame_ok) begin
      len_d     = frame_len;
      sent_d    = 12'd0;
      pad_d     = 1'b0;
      bid_err_d = 1'b0;
    end
    if (state_q == S_ADDR) loaded_d = 9'd0;
    // W stage reloads in the same cycle its current beat drains
    if (s_fire || pad_fire) begin
      wvalid_d = 1'b1;
      wdata_d  = s_fire ? s_data : 16'h0000;
      wlast_d  = (loaded_q + 9'd1 == burst_len);
      loaded_d = loaded_q + 9'd1;
    end else if (wvalid_q && WREADY) begin
      wvalid_d = 1'b0;
      wlast_d  = 1'b0;
    end
    if (s_fire && early) pad_d = 1'b1;
    if (state_q == S_RESP && BVALID) begin
      sent_d = burst_end;
      if (BID != WR_ID) bid_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      len_q     <= 12'd0;
      sent_q    <= 12'd0;
      loaded_q  <= 9'd0;
      pad_q     <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      wdata_q   <= 16'h0000;
      len_err_q <= 1'b0;
      bid_err_q <= 1'b0;
    end else begin
      len_q     <= len_d;
      sent_q    <= sent_d;
      loaded_q  <= loaded_d;
      pad_q     <= pad_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      wdata_q   <= wdata_d;
      len_err_q <= len_err_d;
      bid_err_q <= bid_err_d;
    end
  end

  assign AWSIZE  = 3'b001;
  assign AWBURST = 2'b01;
  assign AWID    = WR_ID;
  assign WSTRB   = 2'b11;
  assign WDATA   = wdata_q;
  assign WVALID  = wvalid_q;
  assign WLAST   = wlast_q;
  assign len_err = len_err_q;
  assign bid_err = bid_err_q;

endmodule

// File: tb/tb_fft_axi_sample_writer.sv
// Scoreboard bench: expected AW/W traffic is derived per frame from the burst/padding rules
// and checked by a monitor that also plays the AXI slave with random stalls.
module tb_fft_axi_sample_writer;
  localparam int MB = 16;
`ifdef FFT_WR_ZERO_PAD_EN
  localparam bit ZPAD = 1'b1;
`else
  localparam bit ZPAD = 1'b0;
`endif

  logic clk, Reset;
  logic [15:0] s_data;
  logic s_valid, s_ready, s_last;
  logic [11:0] frame_len, AWADDR;
  logic [7:0] AWLEN;
  logic [2:0] AWSIZE;
  logic [1:0] AWBURST, AWID, WSTRB, BID;
  logic AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
  logic [15:0] WDATA;
  logic busy, frame_done, cfg_err, len_err, bid_err;

  fft_axi_sample_writer #(.BASE_ADDR(12'h000), .MAX_BURST(MB), .WR_ID(2'b00)) dut (
    .clk(clk), .Reset(Reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .frame_len(frame_len), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWID(AWID), .AWVALID(AWVALID), .AWREADY(AWREADY), .WDATA(WDATA),
    .WSTRB(WSTRB), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY), .BVALID(BVALID),
    .BID(BID), .BREADY(BREADY), .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err),
    .len_err(len_err), .bid_err(bid_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int done_cnt = 0, lerr_cnt = 0, pend_b = 0, stall = 0;
  logic [1:0] bid_val = 2'b00;
  logic [11:0] exp_aa[$];
  logic [7:0]  exp_al[$];
  logic [15:0] exp_wd[$];
  bit          exp_wl[$];
  logic [15:0] samp [0:2047];
  bit b_hs, prev_aw_st, prev_w_st;
  logic [11:0] prev_aa;
  logic [7:0]  prev_al;
  logic [15:0] prev_wd;
  logic        prev_wl;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: bursts of min(MB, remaining); data = real samples then zeros;
  // without zero-pad an early s_last ends the frame at the end of the current burst.
  task automatic expect_frame(input int L, input int n, input bit early);
    int off = 0;
    int bl;
    while (off < L) begin
      bl = (L - off < MB) ? L - off : MB;
      exp_aa.push_back(12'(2 * off));
      exp_al.push_back(8'(bl - 1));
      for (int b = 0; b < bl; b++) begin
        exp_wd.push_back((off + b < n) ? samp[off + b] : 16'h0000);
        exp_wl.push_back(b == bl - 1);
      end
      off += bl;
      if (early && !ZPAD && off >= n) break;
    end
  endtask

  // Monitor (negedge) + AXI slave (posedge+1)
  initial begin
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BID = 2'b00;
    b_hs = 1'b0; prev_aw_st = 1'b0; prev_w_st = 1'b0;
    forever begin
      @(negedge clk);
      if (Reset) begin
        prev_aw_st = 1'b0; prev_w_st = 1'b0; b_hs = 1'b0; pend_b = 0;
      end else begin
        if (prev_aw_st) chk("aw_hold", {AWVALID, AWLEN, AWADDR}, {1'b1, prev_al, prev_aa});
        if (AWVALID && AWREADY) begin
          chk("aw_wait_b", pend_b + (BVALID ? 1 : 0), 0);
          chk("aw_attr", {AWSIZE, AWBURST, AWID}, {3'b001, 2'b01, 2'b00});
          if (exp_aa.size() == 0) chk("aw_unexpected", 1, 0);
          else begin
            chk("aw_addr", AWADDR, exp_aa.pop_front());
            chk("aw_len", AWLEN, exp_al.pop_front());
          end
        end
        prev_aw_st = AWVALID && !AWREADY; prev_aa = AWADDR; prev_al = AWLEN;
        if (prev_w_st) chk("w_hold", {WVALID, WLAST, WDATA}, {1'b1, prev_wl, prev_wd});
        if (WVALID && WREADY) begin
          chk("w_strb", WSTRB, 2'b11);
          if (exp_wd.size() == 0) chk("w_unexpected", 1, 0);
          else begin
            chk("w_data", WDATA, exp_wd.pop_front());
            chk("w_last", WLAST, exp_wl.pop_front());
          end
          if (WLAST) pend_b++;
        end
        prev_w_st = WVALID && !WREADY; prev_wd = WDATA; prev_wl = WLAST;
        b_hs = BVALID && BREADY;
        if (frame_done) done_cnt++;
        if (len_err) lerr_cnt++;
      end
      @(posedge clk); #1;
      if (Reset) begin
        BVALID = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
      end else begin
        if (b_hs) BVALID = 1'b0;
        if (!BVALID && pend_b > 0 && (stall == 0 || $urandom_range(0, 1) == 1)) begin
          BVALID = 1'b1; BID = bid_val; pend_b--;
        end
        AWREADY = (stall == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
        WREADY  = (stall == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
    end
  end

  task automatic send_sample(input logic [15:0] d, input bit lst);
    int t = 0;
    s_data = d; s_last = lst; s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 500) begin
        chk("s_ready_timeout", 1, 0);
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic run_frame(input int L, input int last_idx, input bit incr);
    int n, d0, l0, t;
    bit early;
    for (int i = 0; i < L; i++) samp[i] = incr ? 16'(i) : 16'($urandom);
    early = (last_idx >= 0) && (last_idx < L - 1);
    n = early ? last_idx + 1 : L;
    expect_frame(L, n, early);
    d0 = done_cnt; l0 = lerr_cnt;
    frame_len = 12'(L);
    for (int i = 0; i < n; i++) begin
      if (stall != 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_sample(samp[i], i == last_idx);
    end
    t = 0;
    while (done_cnt == d0 && t < 20000) begin @(posedge clk); t++; end
    repeat (4) @(posedge clk);
    chk("frame_done_count", done_cnt - d0, 1);
    chk("len_err_count", lerr_cnt - l0, (early || last_idx < 0) ? 1 : 0);
    chk("aw_left", exp_aa.size(), 0);
    chk("w_left", exp_wd.size(), 0);
    @(negedge clk);
    chk("busy_after", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int L, r, li;
    Reset = 1'b1; s_valid = 1'b0; s_data = 16'h0; s_last = 1'b0; frame_len = 12'd16;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {AWVALID, WVALID, WLAST, BREADY, s_ready, busy, frame_done, len_err, bid_err, cfg_err}, 0);
    chk("rst_const", {AWSIZE, AWBURST, AWID, WSTRB}, {3'b001, 2'b01, 2'b00, 2'b11});
    chk("rst_data", {AWADDR, AWLEN, WDATA}, 0);
    @(posedge clk); #1 Reset = 1'b0;

    stall = 0; run_frame(16, 15, 1);
    stall = 0; run_frame(40, 39, 0);
    stall = 1; run_frame(20, 19, 1);
    stall = 1; run_frame(16, 5, 0);
    stall = 1; run_frame(40, 5, 0);
    stall = 1; run_frame(10, -1, 0);

    bid_val = 2'b01; run_frame(17, 16, 0);
    @(negedge clk); chk("bid_err_set", bid_err, 1);
    @(posedge clk); #1 bid_val = 2'b00;

    frame_len = 12'd0; s_valid = 1'b1; s_data = 16'hdead;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("cfg_err_zero", cfg_err, 1);
    chk("cfg_no_start", {busy, AWVALID}, 0);
    @(posedge clk); #1 frame_len = 12'd2049;
    @(negedge clk); chk("cfg_err_big", cfg_err, 1);
    chk("bid_err_sticky", bid_err, 1);
    @(posedge clk); #1 s_valid = 1'b0; frame_len = 12'd16;
    @(negedge clk); chk("cfg_err_clear", cfg_err, 0);
    @(posedge clk); #1;

    run_frame(1, 0, 0);
    @(negedge clk); chk("bid_err_cleared", bid_err, 0);
    @(posedge clk); #1;

    stall = 0; run_frame(2048, 2047, 0);
    stall = 1;
    for (int k = 0; k < 5; k++) begin
      L = $urandom_range(1, 50);
      r = $urandom_range(0, 3);
      li = (r == 0) ? -1 : (r == 1) ? $urandom_range(0, L - 1) : L - 1;
      run_frame(L, li, 0);
    end

    // abandon a burst mid-flight
    stall = 0; frame_len = 12'd40;
    for (int i = 0; i < 40; i++) samp[i] = 16'($urandom);
    expect_frame(40, 40, 1'b0);
    for (int i = 0; i < 8; i++) send_sample(samp[i], 1'b0);
    #2 Reset = 1'b1;
    #1;
    chk("rst_mid_ctrl", {AWVALID, WVALID, WLAST, BREADY, s_ready, busy, frame_done, len_err}, 0);
    chk("rst_mid_data", {AWADDR, WDATA}, 0);
    exp_aa.delete(); exp_al.delete(); exp_wd.delete(); exp_wl.delete();
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    run_frame(16, 15, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_axi_sample_writer.md
# fft_axi_sample_writer

Upstream feeder for the FFT core's AXI write slave port. It accepts a frame of 16-bit samples on a valid/ready stream and stores them as AXI INCR write bursts into the FFT sample memory, starting at `BASE_ADDR`. It keeps one burst outstanding at a time, checks each write response, and pulses `frame_done` when the whole frame has been acknowledged. The FFT can then be started with `SAMP_NUMBER = frame_len`.

## Interface
- `BASE_ADDR`, default 12'h000: byte address of sample 0. Must be 2-byte aligned.
- `MAX_BURST`, default 16: maximum beats per burst, range 1..256.
- `WR_ID`, default 2'b00: value driven on `AWID` and expected on `BID`.
- `clk` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-high.
- `s_data` in 16: sample.
- `s_valid` in 1: sample valid.
- `s_ready` out 1: sample accepted when `s_valid & s_ready`.
- `s_last` in 1: producer's end-of-frame marker.
- `frame_len` in 12: samples per frame. Sampled on frame start. Legal range 1..2048.
- `AWADDR` out 12, `AWLEN` out 8, `AWSIZE` out 3, `AWBURST` out 2, `AWID` out 2, `AWVALID` out 1, `AWREADY` in 1: write address channel.
- `WDATA` out 16, `WSTRB` out 2, `WVALID` out 1, `WLAST` out 1, `WREADY` in 1: write data channel.
- `BVALID` in 1, `BID` in 2, `BREADY` out 1: write response channel.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse when the frame completes.
- `cfg_err` out 1: level; `frame_len` is illegal while idle.
- `len_err` out 1: one-cycle pulse on an `s_last` mismatch.
- `bid_err` out 1: sticky; set when `BID != WR_ID`, cleared on the next frame start.

## Operation
- States: IDLE → ADDR → DATA → RESP → (ADDR | DONE) → IDLE.
- **IDLE:**
  - `s_ready = 0`.
  - If `s_valid` and `frame_len` is legal, latch `frame_len`, clear the address offset, and go to ADDR.
  - If `frame_len` is illegal, stay in IDLE and hold `cfg_err = 1`.
- **ADDR:**
  - Drive `AWVALID = 1`.
  - `AWADDR = BASE_ADDR + 2*sent`, `AWLEN = min(MAX_BURST, remaining) - 1`, `AWSIZE = 3'b001`, `AWBURST = 2'b01`, `AWID = WR_ID`.
  - Outputs are held stable until `AWREADY`; then go to DATA.
- **DATA:**
  - Single-entry registered W stage.
  - `s_ready = (!WVALID | WREADY) & (beats_loaded < burst_len)`.
  - Each accepted sample loads `WDATA` and sets `WVALID`.
  - `WSTRB = 2'b11` on every beat.
  - `WLAST = 1` on the final beat of the burst.
  - When the final beat handshakes, go to RESP.
- **RESP:**
  - `BREADY = 1`.
  - On `BVALID`: compare `BID` with `WR_ID`, then go to ADDR if samples remain, otherwise DONE.
- **DONE:** pulse `frame_done` for one cycle, then return to IDLE.
- Address arithmetic is 12-bit with no wrap checking. A legal `frame_len` with `BASE_ADDR = 0` never wraps.
- **Frame end:** the frame always ends after `frame_len` samples.
  - `s_last` arriving earlier, or absent on sample `frame_len`, pulses `len_err` in the cycle after that handshake.
  - Samples after the frame end are not consumed until the next frame.
- **Early `s_last` (padding):** the current burst is completed with zero beats. `s_ready` is 0 while padding.
- **Reset, including mid-burst:** state returns to IDLE immediately and the partial burst is abandoned.
- **Reset value of every output is 0**, except `AWSIZE = 3'b001`, `AWBURST = 2'b01`, `AWID = WR_ID`, `WSTRB = 2'b11`.

## Timing
- IDLE with a legal start → `AWVALID` high on the next cycle.
- `AWREADY` handshake → first `s_ready` on the next cycle.
- Sample handshake → `WVALID`/`WDATA` on the next cycle. Sustained throughput is 1 beat/cycle while `WREADY = 1`.
- Final W handshake → `BREADY` on the next cycle.
- `BVALID` handshake → `AWVALID` for the next burst, or the `frame_done` pulse, one cycle later. `busy` falls together with `frame_done`.
- `WVALID` and `AWVALID` never drop without a handshake.
- `BID` is ignored outside RESP.

## Configuration
- `FFT_WR_ZERO_PAD_EN` defined:
  - An early `s_last` makes the block zero-pad to the full `frame_len`, not just to the end of the current burst.
  - Further bursts are issued with zero data.
  - `s_ready` stays 0 until DONE.
- Not defined:
  - An early `s_last` only pads the current burst.
  - The frame is then truncated and DONE follows the response.
  - `len_err` still pulses in both builds.

## Test plan
- `frame_len=16`, `MAX_BURST=16`, 16 samples 0..15, slave always ready → one burst with `AWADDR=0`, `AWLEN=15`, `WLAST` on beat 15, `frame_done` once.
- `frame_len=40`, `MAX_BURST=16` → three bursts, `AWADDR` 0/32/64 and `AWLEN` 15/15/7. Each AW waits for the prior B.
- Random `WREADY`/`AWREADY` stalls on a 20-sample frame → `WDATA`/`AWADDR` stable while stalled, memory holds 0..19 in order.
- `s_last` on sample 5 of a 16-sample frame → `len_err` pulse, beats 6..15 are 0, `frame_done`. With the macro, same result for a 40-sample frame across all 3 bursts.
- `BID=2'b01` with `WR_ID=0` → `bid_err=1` until the next start. `frame_len=0` → `cfg_err=1`, no AW issued.
- Assert `Reset` mid-burst → all outputs at reset values in the same cycle; a new frame after release starts at `AWADDR=BASE_ADDR`.
